// File: rtl/synth_audio_pkg.sv
// Shared audio datapath constants and I2S slot helper for the filter and I2S blocks.
package synth_audio_pkg;

    localparam int unsigned SAMPLE_W    = 24;
    localparam int unsigned SLOT_W      = 32;
    localparam int unsigned FRAME_SLOTS = 64;
    localparam int unsigned SLOT_CNT_W  = $clog2(FRAME_SLOTS);

    typedef logic [SAMPLE_W-1:0]   sample_t;
    typedef logic [SLOT_CNT_W-1:0] slot_t;

    // Serial bit for a frame slot: MSB one slot after the channel edge, zero padding elsewhere.
    function automatic logic slot_bit(input sample_t word, input slot_t slot);
        logic [4:0] k;
        logic [4:0] idx;
        k   = slot[4:0];
        idx = 5'(SAMPLE_W) - k;
        if (k >= 5'd1 && k <= 5'(SAMPLE_W)) begin
            return word[idx];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: Bclk plus strobes marking the cycle whose closing edge
// makes Bclk fall (fall_tick) or rise (rise_tick).
module i2s_bclk_gen #(
    parameter int unsigned BCLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int unsigned DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE_RISE = DIV_W'(BCLK_DIV / 2 - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;

    assign fall_tick = (div_q == DIV_LAST);
    assign rise_tick = (div_q == DIV_PRE_RISE);
    assign bclk      = bclk_q;

    always_comb begin
        div_d  = fall_tick ? '0 : div_q + DIV_W'(1);
        bclk_d = bclk_q;
        if (fall_tick) begin
            bclk_d = 1'b0;
        end else if (rise_tick) begin
            bclk_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo I2S transmitter with a one-entry sample holding register.
// Optional UnderrunCount output when I2S_TX_UNDERRUN_CNT_EN is defined.
module i2s_tx
    import synth_audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [SAMPLE_W-1:0] SampleIn,
    input  logic                SampleValid,
    output logic                SampleReady,
    output logic                Bclk,
    output logic                Lrclk,
    output logic                Sdata,
    output logic                Underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         UnderrunCount
`endif
);

    logic    fall_tick, rise_tick;
    logic    load, accept;

    slot_t   slot_q, slot_d;
    logic    sdata_q, sdata_d;
    logic    next_bit_q, next_bit_d;
    sample_t active_q, active_d;
    sample_t hold_q, hold_d;
    logic    full_q, full_d;
    logic    underrun_q, underrun_d;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk       (Clock),
        .rst_n     (Reset),
        .bclk      (Bclk),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    assign load   = fall_tick && (slot_q == slot_t'(FRAME_SLOTS - 1));
    assign accept = SampleValid && !full_q;

    always_comb begin
        slot_d     = slot_q;
        sdata_d    = sdata_q;
        next_bit_d = next_bit_q;
        active_d   = active_q;
        hold_d     = hold_q;
        full_d     = full_q;
        underrun_d = load && !full_q;
        // Next slot's bit is looked up mid-slot so the fall edge only moves a flop.
        // Slot 0 is always padding, so a new active word is never needed before slot 1.
        if (rise_tick) begin
            next_bit_d = slot_bit(active_q, slot_q + slot_t'(1));
        end
        if (fall_tick) begin
            slot_d  = slot_q + slot_t'(1);
            sdata_d = next_bit_q;
        end
        if (load) begin
            active_d = full_q ? hold_q : '0;
        end
        if (load && full_q) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d = 1'b1;
            hold_d = SampleIn;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            slot_q     <= '0;
            sdata_q    <= 1'b0;
            next_bit_q <= 1'b0;
            active_q   <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            sdata_q    <= sdata_d;
            next_bit_q <= next_bit_d;
            active_q   <= active_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            underrun_q <= underrun_d;
        end
    end

    assign SampleReady = !full_q;
    assign Lrclk       = slot_q[SLOT_CNT_W-1];
    assign Sdata       = sdata_q;
    assign Underrun    = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            underrun_cnt_q <= '0;
        end else if (underrun_q && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign UnderrunCount = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: a frame-level model predicts each frame's word and
// underrun flag; a monitor deserialises Sdata on Bclk rises and checks them.
module tb_i2s_tx;

    localparam int DIV = 4;
    localparam int P   = 64 * DIV;

    typedef struct packed {
        logic [23:0] w;
        logic        urun;
    } exp_frame_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [23:0] SampleIn = '0;
    logic        SampleValid = 1'b0;
    logic        SampleReady;
    logic        Bclk;
    logic        Lrclk;
    logic        Sdata;
    logic        Underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] UnderrunCount;
    int          m_ucnt = 0;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          t = 0;
    logic        m_full = 1'b0;
    logic [23:0] m_hold = '0;
    logic [23:0] pend[$];
    exp_frame_t  exp_q[$];
    logic        rst_seen;

    i2s_tx #(
        .BCLK_DIV (DIV)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .SampleIn      (SampleIn),
        .SampleValid   (SampleValid),
        .SampleReady   (SampleReady),
        .Bclk          (Bclk),
        .Lrclk         (Lrclk),
        .Sdata         (Sdata),
        .Underrun      (Underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .UnderrunCount (UnderrunCount)
`endif
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) rst_seen <= Reset;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    function automatic logic exp_bit(input logic [23:0] w, input int s);
        int k;
        k = s % 32;
        if (k >= 1 && k <= 24) return w[24 - k];
        return 1'b0;
    endfunction

    // Reset held for n cycles; a sample offered meanwhile must be dropped.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            Reset       = 1'b0;
            SampleValid = 1'b1;
            SampleIn    = 24'($urandom);
        end
        exp_q.delete();
        pend.delete();
        m_full = 1'b0;
        t      = 0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        m_ucnt = 0;
`endif
        exp_q.push_back('{w: 24'h0, urun: 1'b0});
    endtask

    task automatic step();
        logic hs;
        @(negedge Clock);
        Reset = 1'b1;
        if (pend.size() > 0) begin
            SampleValid = 1'b1;
            SampleIn    = pend[0];
        end else begin
            SampleValid = 1'b0;
            SampleIn    = 24'($urandom);
        end
        check("ready", 64'(SampleReady), 64'(!m_full));
        hs = SampleValid && !m_full;
        if (t % P == P - 1) begin
            if (m_full) begin
                exp_q.push_back('{w: m_hold, urun: 1'b0});
                m_full = 1'b0;
            end else begin
                exp_q.push_back('{w: 24'h0, urun: 1'b1});
`ifdef I2S_TX_UNDERRUN_CNT_EN
                if (m_ucnt < 16'hFFFF) m_ucnt++;
`endif
            end
        end
        if (hs) begin
            m_full = 1'b1;
            m_hold = SampleIn;
            void'(pend.pop_front());
        end
        t++;
    endtask

    task automatic run_until(input int target);
        while (t < target) step();
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            if (pend.size() == 0 && $urandom_range(0, 199) == 0) pend.push_back(24'($urandom));
            step();
        end
    endtask

    task automatic check_count();
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_count", 64'(UnderrunCount), 64'(m_ucnt));
`endif
    endtask

    initial begin : monitor
        logic        prev_bclk;
        logic [1:0]  prev_ls;
        int          rises;
        int          urun_seen;
        int          cyc;
        int          last_start;
        logic [5:0]  sl;
        logic [63:0] bits;
        logic [63:0] eb;
        exp_frame_t  e;
        prev_bclk = 1'b0; prev_ls = '0; rises = 0; urun_seen = 0; cyc = 0; last_start = -1;
        bits = '0;
        forever begin
            @(negedge Clock);
            if (rst_seen !== 1'b1) begin
                check("reset_outputs", 64'({Bclk, Lrclk, Sdata, Underrun, SampleReady}),
                      64'(5'b00001));
                // This cycle is also cycle 0 of the first frame; the next one is cycle 1.
                prev_bclk = 1'b0; prev_ls = '0; rises = 0; urun_seen = 0;
                cyc = 1; last_start = -1;
            end else begin
                check("bclk_phase", 64'(Bclk), 64'((cyc % DIV) >= DIV / 2));
                if (Underrun === 1'b1) urun_seen++;
                if (Bclk === 1'b1 && prev_bclk === 1'b0) begin
                    sl = 6'(rises % 64);
                    check("lrclk", 64'(Lrclk), 64'(sl[5]));
                    check("stable_at_rise", 64'({Lrclk, Sdata}), 64'(prev_ls));
                    bits[sl] = Sdata;
                    if (sl == 6'd0) begin
                        if (last_start >= 0) check("frame_period", 64'(cyc - last_start), 64'(P));
                        last_start = cyc;
                    end
                    if (sl == 6'd63) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL frame_queue: got frame with no expectation queued");
                        end else begin
                            e = exp_q.pop_front();
                            for (int s = 0; s < 64; s++) eb[s] = exp_bit(e.w, s);
                            check("frame_data", bits, eb);
                            check("frame_underrun", 64'(urun_seen), 64'(e.urun));
                        end
                        urun_seen = 0;
                    end
                    rises++;
                end
                prev_bclk = Bclk;
                prev_ls   = {Lrclk, Sdata};
                cyc++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin : driver
        do_reset(4);
        // Single sample in frame 0 plays in frame 1; frame 2 starves.
        run_until(10);
        pend.push_back(24'hA5C3F1);
        run_until(2 * P + 20);
        check_count();
        // Back-pressure: three samples queued back-to-back.
        pend.push_back(24'h000001);
        pend.push_back(24'h000002);
        pend.push_back(24'h000003);
        run_until(6 * P - 1);
        // Offer a sample exactly in the load cycle with hold empty.
        pend.push_back(24'h5A5A5A);
        run_until(7 * P + 40 * DIV);
        do_reset(3);
        run_random(30 * P);
        run_until(((t / P) + 2) * P + 100);
        check_count();
        check("frame_backlog", 64'(exp_q.size()), 64'(1));
`ifdef I2S_TX_UNDERRUN_CNT_EN
        @(negedge Clock);
        force dut.underrun_cnt_q = 16'hFFFF;
        @(negedge Clock);
        release dut.underrun_cnt_q;
        m_ucnt = 16'hFFFF;
        pend.delete();
        run_until(((t / P) + 2) * P + 20);
        check_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
